// File: rtl/mem_stage_apb_pkg.sv
// Shared constants and types for the APB memory stage and its bench.
package mem_stage_apb_pkg;

  localparam int APB_DW = 16;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Request captured in IDLE and held for the whole APB transfer
  typedef struct packed {
    logic [31:0]       paddr;
    logic [APB_DW-1:0] wdata;
    logic              pwrite;
    logic [2:0]        rd;
    logic              reg_write;
  } mem_req_t;

endpackage

// File: rtl/apb_master_fsm.sv
// APB master sequencing: IDLE -> SETUP -> ACCESS with bounded wait and stall.
module apb_master_fsm
  import mem_stage_apb_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op,
  input  logic pready,
  output logic psel,
  output logic penable,
  output logic stall,
  output logic capture,
  output logic done,
  output logic abort
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  // Abort fires in the cycle the counter would reach WAIT_MAX
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          in_setup, in_access;

  assign in_setup  = (state == ST_SETUP);
  assign in_access = (state == ST_ACCESS);
  assign capture   = (state == ST_IDLE) && mem_op;
  assign done      = in_access && pready;
  assign abort     = in_access && !pready && (wait_cnt == CNT_LAST);
  assign psel      = in_setup || in_access;
  assign penable   = in_access;
  // Gated by reset so an async reset silences stall even with a request pending
  assign stall     = rst && (capture || in_setup || (in_access && !pready && !abort));

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (mem_op) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (done || abort) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register and ACCESS wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (in_access && !pready && !abort) wait_cnt <= wait_cnt + 1'b1;
      else                                wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_stage_apb.sv
// Memory stage: APB loads/stores, pass-through otherwise, MEM/WB register.
module mem_stage_apb
  import mem_stage_apb_pkg::*;
#(
  parameter logic [15:0] ADDR_HI  = 16'h0000,
  parameter int          WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       addr,
  input  logic [APB_DW-1:0] wdata,
  input  logic [2:0]        rd_in,
  input  logic              reg_write_in,
  input  logic [APB_DW-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic [31:0]       paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [APB_DW-1:0] pwdata,
  output logic              stall,
  output logic [APB_DW-1:0] mem_data,
  output logic [2:0]        rd_out,
  output logic              reg_write_out,
  output logic              err
);

  logic     capture, done, abort;
  mem_req_t req;

  apb_master_fsm #(.WAIT_MAX(WAIT_MAX)) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .mem_op  (mem_read | mem_write),
    .pready  (pready),
    .psel    (psel),
    .penable (penable),
    .stall   (stall),
    .capture (capture),
    .done    (done),
    .abort   (abort)
  );

  assign paddr  = req.paddr;
  assign pwrite = req.pwrite;
  assign pwdata = req.wdata;

  // Request capture and MEM/WB result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req           <= '0;
      mem_data      <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      err           <= 1'b0;
    end else if (capture) begin
      // Write wins on a read/write conflict; the conflict itself is an error
      req           <= '{paddr: {ADDR_HI, addr}, wdata: wdata, pwrite: mem_write,
                         rd: rd_in, reg_write: reg_write_in};
      reg_write_out <= 1'b0;
      if (mem_read && mem_write) err <= 1'b1;
    end else if (!psel) begin
      mem_data      <= addr;
      rd_out        <= rd_in;
      reg_write_out <= reg_write_in;
    end else if (done) begin
      mem_data      <= req.pwrite ? req.paddr[15:0] : prdata;
      rd_out        <= req.rd;
      reg_write_out <= req.reg_write && !req.pwrite;
      if (pslverr) err <= 1'b1;
    end else if (abort) begin
      reg_write_out <= 1'b0;
      err           <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage_apb.sv
// Directed bench for mem_stage_apb; inputs driven 1ns after rising edges.
module tb_mem_stage_apb;
  import mem_stage_apb_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_read, mem_write, reg_write_in, pready, pslverr;
  logic [15:0]       addr;
  logic [APB_DW-1:0] wdata, prdata;
  logic [2:0]        rd_in;
  logic [31:0]       paddr;
  logic              psel, penable, pwrite, stall, reg_write_out, err;
  logic [APB_DW-1:0] pwdata, mem_data;
  logic [2:0]        rd_out;

  int checks = 0;
  int errors = 0;

  mem_stage_apb #(.ADDR_HI(16'h0000), .WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .stall(stall), .mem_data(mem_data), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0; pready = 0; pslverr = 0;
    addr = 16'h0; wdata = 16'h0; rd_in = 3'd0; reg_write_in = 0; prdata = 16'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    tick(); tick();
    checks++; if ({psel, penable, pwrite, stall, reg_write_out, err} !== 6'b0) begin errors++; $display("FAIL reset_ctl got %b exp 000000", {psel, penable, pwrite, stall, reg_write_out, err}); end
    checks++; if ({paddr, pwdata, mem_data, rd_out} !== 67'b0) begin errors++; $display("FAIL reset_data got %h/%h/%h/%h exp 0", paddr, pwdata, mem_data, rd_out); end
    rst = 1;
    tick();
  endtask

  task automatic test_pass_through();
    addr = 16'h1234; rd_in = 3'd3; reg_write_in = 1;
    #1;
    checks++; if (stall !== 1'b0 || psel !== 1'b0) begin errors++; $display("FAIL pt_stall got stall=%b psel=%b exp 0 0", stall, psel); end
    tick();
    addr = 16'h0; rd_in = 3'd0; reg_write_in = 0;
    #1;
    checks++; if (mem_data !== 16'h1234 || rd_out !== 3'd3 || reg_write_out !== 1'b1) begin errors++; $display("FAIL pt_result got %h/%0d/%b exp 1234/3/1", mem_data, rd_out, reg_write_out); end
    checks++; if (stall !== 1'b0 || psel !== 1'b0) begin errors++; $display("FAIL pt_after got stall=%b psel=%b exp 0 0", stall, psel); end
  endtask

  task automatic test_load();
    mem_read = 1; addr = 16'h0040; rd_in = 3'd5; reg_write_in = 1;
    #1;
    checks++; if (stall !== 1'b1 || psel !== 1'b0) begin errors++; $display("FAIL ld_capture got stall=%b psel=%b exp 1 0", stall, psel); end
    tick();
    checks++; if ({psel, penable, stall, pwrite} !== 4'b1010 || paddr !== 32'h0000_0040 || reg_write_out !== 1'b0) begin errors++; $display("FAIL ld_setup got ctl=%b paddr=%h rw=%b exp 1010 00000040 0", {psel, penable, stall, pwrite}, paddr, reg_write_out); end
    tick();
    pready = 1; prdata = 16'hBEEF;
    #1;
    checks++; if ({psel, penable, stall} !== 3'b110) begin errors++; $display("FAIL ld_access got %b exp 110", {psel, penable, stall}); end
    tick();
    idle_inputs();
    #1;
    checks++; if (mem_data !== 16'hBEEF || rd_out !== 3'd5 || reg_write_out !== 1'b1) begin errors++; $display("FAIL ld_result got %h/%0d/%b exp BEEF/5/1", mem_data, rd_out, reg_write_out); end
    checks++; if ({psel, penable, stall} !== 3'b000) begin errors++; $display("FAIL ld_release got %b exp 000", {psel, penable, stall}); end
  endtask

  task automatic test_store_wait();
    mem_write = 1; addr = 16'h0010; wdata = 16'hA5A5; rd_in = 3'd2; reg_write_in = 1;
    tick();
    checks++; if (pwrite !== 1'b1 || pwdata !== 16'hA5A5 || paddr !== 32'h10) begin errors++; $display("FAIL st_setup got pw=%b wd=%h pa=%h exp 1 A5A5 00000010", pwrite, pwdata, paddr); end
    tick();
    for (int i = 0; i < 5; i++) begin
      pready = (i == 4);
      #1;
      checks++; if ({psel, penable, pwrite, stall} !== {3'b111, i != 4} || pwdata !== 16'hA5A5 || paddr !== 32'h10) begin errors++; $display("FAIL st_access%0d got ctl=%b wd=%h pa=%h exp %b A5A5 00000010", i, {psel, penable, pwrite, stall}, pwdata, paddr, {3'b111, i != 4}); end
      if (i < 4) tick();
    end
    tick();
    idle_inputs();
    #1;
    checks++; if (reg_write_out !== 1'b0 || mem_data !== 16'h0010 || rd_out !== 3'd2 || err !== 1'b0) begin errors++; $display("FAIL st_result got rw=%b md=%h rd=%0d err=%b exp 0 0010 2 0", reg_write_out, mem_data, rd_out, err); end
  endtask

  task automatic test_timeout();
    mem_read = 1; addr = 16'h0080; rd_in = 3'd1; reg_write_in = 1;
    tick(); tick();
    for (int i = 0; i < 15; i++) begin
      #1;
      checks++; if ({psel, penable, stall} !== {2'b11, i != 14}) begin errors++; $display("FAIL to_access%0d got %b exp %b", i, {psel, penable, stall}, {2'b11, i != 14}); end
      tick();
    end
    idle_inputs();
    #1;
    checks++; if ({psel, penable, stall, err, reg_write_out} !== 5'b00010) begin errors++; $display("FAIL to_abort got %b exp 00010", {psel, penable, stall, err, reg_write_out}); end
    checks++; if (mem_data !== 16'h0010) begin errors++; $display("FAIL to_no_wb got %h exp 0010", mem_data); end
  endtask

  task automatic test_conflict_slverr();
    rst = 0; #2; rst = 1;
    tick();
    mem_read = 1; mem_write = 1; addr = 16'h0020; wdata = 16'h5555; rd_in = 3'd6; reg_write_in = 1;
    tick();
    checks++; if (pwrite !== 1'b1 || err !== 1'b1 || pwdata !== 16'h5555) begin errors++; $display("FAIL cf_setup got pw=%b err=%b wd=%h exp 1 1 5555", pwrite, err, pwdata); end
    tick();
    pready = 1;
    tick();
    idle_inputs();
    #1;
    checks++; if (reg_write_out !== 1'b0 || mem_data !== 16'h0020) begin errors++; $display("FAIL cf_result got rw=%b md=%h exp 0 0020", reg_write_out, mem_data); end
    mem_read = 1; addr = 16'h0030; rd_in = 3'd4; reg_write_in = 1;
    tick(); tick();
    pready = 1; pslverr = 1; prdata = 16'h1357;
    tick();
    idle_inputs();
    #1;
    checks++; if (mem_data !== 16'h1357 || rd_out !== 3'd4 || reg_write_out !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL se_result got %h/%0d/%b/%b exp 1357/4/1/1", mem_data, rd_out, reg_write_out, err); end
  endtask

  task automatic test_async_reset();
    mem_read = 1; addr = 16'h0050; rd_in = 3'd7; reg_write_in = 1;
    tick(); tick();
    #1;
    checks++; if ({psel, penable, stall} !== 3'b111) begin errors++; $display("FAIL ar_pre got %b exp 111", {psel, penable, stall}); end
    #1 rst = 0;
    #1;
    checks++; if ({psel, penable, stall, reg_write_out, err} !== 5'b0) begin errors++; $display("FAIL ar_drop got %b exp 00000", {psel, penable, stall, reg_write_out, err}); end
    idle_inputs();
    tick();
    rst = 1;
    tick();
    test_pass_through();
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load();
    test_store_wait();
    test_timeout();
    test_conflict_slverr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
